usd_data_rd: RTL

USD_DATA_RD -- requirements
Module: usd_data_rd

---
 rtl/usd_data_rd.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/usd_data_rd.sv
// usd_data_rd: SD card multi-block DAT read path (1-bit or 4-bit bus), packing received bits into OUT_WIDTH words.
// Optional per-line CRC16 checking is built when USD_RD_CRC_EN is defined.
module usd_data_rd #(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned OUT_WIDTH      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 sdClk,
  input  logic                 sysRst,
  input  logic                 readCmd,
  input  logic                 wideBus,
  input  logic [15:0]          blockCount,
  input  logic [3:0]           sdDataIn,
  input  logic                 readFifoAlmostFull,
  output logic [OUT_WIDTH-1:0] readDataOut,
  output logic                 readFifoWe,
  output logic                 readDone,
  output logic [3:0]           dataStatus,
  output logic                 busy
);
  localparam int unsigned DW_RAW = $clog2(BLOCK_BYTES * 8);
  localparam int unsigned DW     = (DW_RAW < 4) ? 4 : DW_RAW;
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FW     = $clog2(OUT_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, HOLD, DONE} state_t;

  state_t               state_q, state_d;
  logic                 wide_q, wide_d;
  logic [15:0]          blk_q, blk_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [OUT_WIDTH-1:0] sr_q, sr_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic [3:0]           status_q, status_d;
  logic                 busy_q, busy_d;

  logic [3:0]           used_c;
  logic                 start_c;
  logic [OUT_WIDTH-1:0] shift_c;
  logic [FW-1:0]        fill_sum_c;
  logic [DW-1:0]        data_last_c;
  logic                 crc_err_c;

  assign used_c      = wide_q ? 4'hF : 4'h1;
  assign start_c     = wide_q ? (sdDataIn == 4'h0) : ~sdDataIn[0];
  assign shift_c     = wide_q ? ((sr_q << 4) | OUT_WIDTH'(sdDataIn))
                              : ((sr_q << 1) | OUT_WIDTH'(sdDataIn[0]));
  assign fill_sum_c  = fill_q + (wide_q ? FW'(4) : FW'(1));
  assign data_last_c = wide_q ? DW'(BLOCK_BYTES * 2 - 1) : DW'(BLOCK_BYTES * 8 - 1);

`ifdef USD_RD_CRC_EN
  // One CRC16 (x^16+x^12+x^5+1) per DAT line; shifted out MSB-first against the received CRC.
  logic [15:0] crc_q [4];
  logic [15:0] crc_d [4];

  always_comb begin
    crc_err_c = 1'b0;
    for (int l = 0; l < 4; l++) begin
      crc_d[l] = crc_q[l];
      if (state_q == WAIT_START) begin
        crc_d[l] = 16'h0000;
      end else if (state_q == DATA) begin
        crc_d[l] = {crc_q[l][14:0], 1'b0} ^ ((sdDataIn[l] ^ crc_q[l][15]) ? 16'h1021 : 16'h0000);
      end else if (state_q == CRC) begin
        crc_d[l] = {crc_q[l][14:0], 1'b0};
        if (used_c[l] && (sdDataIn[l] != crc_q[l][15])) crc_err_c = 1'b1;
      end
    end
  end

  always_ff @(posedge sdClk or posedge sysRst) begin
    if (sysRst) begin
      for (int l = 0; l < 4; l++) crc_q[l] <= 16'h0000;
    end else begin
      for (int l = 0; l < 4; l++) crc_q[l] <= crc_d[l];
    end
  end
`else
  assign crc_err_c = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wide_d   = wide_q;
    blk_d    = blk_q;
    tcnt_d   = tcnt_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    we_d     = 1'b0;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (readCmd) begin
          state_d  = WAIT_START;
          wide_d   = wideBus;
          blk_d    = (blockCount == 16'd0) ? 16'd1 : blockCount;
          tcnt_d   = '0;
          status_d = 4'h0;
        end
      end
      WAIT_START: begin
        if (start_c) begin
          state_d = DATA;
          cnt_d   = '0;
          fill_d  = '0;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
          state_d     = DONE;
          status_d[2] = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DATA: begin
        sr_d = shift_c;
        if (fill_sum_c == FW'(OUT_WIDTH)) begin
          dout_d = shift_c;
          we_d   = 1'b1;
          fill_d = '0;
        end else begin
          fill_d = fill_sum_c;
        end
        if (cnt_q == data_last_c) begin
          state_d = CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      CRC: begin
        if (crc_err_c) status_d[0] = 1'b1;
        if (cnt_q == DW'(15)) state_d = END;
        else cnt_d = cnt_q + DW'(1);
      end
      END: begin
        if ((~sdDataIn & used_c) != 4'h0) status_d[1] = 1'b1;
        if (blk_q != 16'd0) blk_d = blk_q - 16'd1;
        if (blk_q <= 16'd1) begin
          state_d = DONE;
        end else if (readFifoAlmostFull) begin
          state_d     = HOLD;
          status_d[3] = 1'b1;
        end else begin
          state_d = WAIT_START;
          tcnt_d  = '0;
        end
      end
      HOLD: begin
        if (!readFifoAlmostFull) begin
          state_d = WAIT_START;
          tcnt_d  = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // DONE is always left after one cycle, so entering it is a single-cycle pulse.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sdClk or posedge sysRst) begin
    if (sysRst) begin
      state_q  <= IDLE;
      wide_q   <= 1'b0;
      blk_q    <= 16'd0;
      tcnt_q   <= '0;
      cnt_q    <= '0;
      fill_q   <= '0;
      sr_q     <= '0;
      dout_q   <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 4'h0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wide_q   <= wide_d;
      blk_q    <= blk_d;
      tcnt_q   <= tcnt_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      we_q     <= we_d;
      done_q   <= done_d;
      status_q <= status_d;
      busy_q   <= busy_d;
    end
  end

  assign readDataOut = dout_q;
  assign readFifoWe  = we_q;
  assign readDone    = done_q;
  assign dataStatus  = status_q;
  assign busy        = busy_q;

endmodule
